uart_pulse_cmd_parser: RTL and testbench

Parametrised UART command-frame parser for the multi-channel pulse generator. It consumes the byte stream from `uart_rx` (`po_data`/`po_flag`) and validates fixed-length frames by header, checksum and inter-byte timeout. It commits per-channel pulse widths, inter-pulse gap and channel enables atomically, then issues a single trigger to the pulse engine. It also returns an ACK/NAK byte to `uart_tx` and merges the debounced key trigger into the same trigger output.

---
 rtl/uart_pulse_cmd_parser.sv | 146 ++++++++++++++
 tb/tb_uart_pulse_cmd_parser.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pulse_cmd_parser.sv
// UART command-frame parser: collects fixed-length frames, validates header, checksum and
// inter-byte timeout, commits pulse parameters atomically and merges key/frame triggers.
module uart_pulse_cmd_parser #(
   parameter int unsigned CH_NUM      = 2,
   parameter logic [7:0]  HEADER      = 8'h07,
   parameter logic [25:0] TIMEOUT_CYC = 26'd5_000_000,
   parameter logic [15:0] RST_WIDTH   = 16'd5,
   parameter logic [15:0] RST_GAP     = 16'd5,
   parameter logic [7:0]  ACK_OK      = 8'hA5,
   parameter logic [7:0]  ACK_BAD     = 8'h5A
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic [7:0]           pi_data,
   input  logic                 pi_flag,
   input  logic                 key_trig,
   output logic [CH_NUM*16-1:0] pulse_width,
   output logic [15:0]          pulse_gap,
   output logic [CH_NUM-1:0]    ch_en,
   output logic                 trig,
   output logic [7:0]           ack_data,
   output logic                 ack_flag,
   output logic                 frame_err,
   output logic [1:0]           dbg_state
);

   localparam int unsigned FRAME_LEN = 2 * CH_NUM + 5;
   localparam int          CW        = $clog2(FRAME_LEN);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RECV  = 2'd1,
      S_CHECK = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [CW-1:0]       r_cnt;
   logic [7:0]          r_sum;
   logic [25:0]         r_idle;
   logic [CH_NUM-1:0]   r_mask;
   logic [15:0]         r_width [CH_NUM];
   logic [15:0]         r_gap;
   logic [7:0]          r_csum;
   logic                r_trig_pend;
   logic                w_last;
   logic                w_timeout;
   logic                w_match;

   assign w_last    = pi_flag && (r_cnt == CW'(FRAME_LEN - 1));
   assign w_timeout = !pi_flag && (r_idle == TIMEOUT_CYC - 26'd1);
   assign w_match   = (r_csum == r_sum);
   assign dbg_state = r_state;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (pi_flag && (pi_data == HEADER)) w_next = S_RECV;
         S_RECV: begin
            if (w_last)         w_next = S_CHECK;
            else if (w_timeout) w_next = S_IDLE;
         end
         S_CHECK: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) r_state <= S_IDLE;
      else            r_state <= w_next;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_cnt       <= '0;
         r_sum       <= '0;
         r_idle      <= '0;
         r_mask      <= '0;
         r_gap       <= '0;
         r_csum      <= '0;
         r_trig_pend <= 1'b0;
         for (int k = 0; k < int'(CH_NUM); k++) r_width[k] <= '0;
         pulse_width <= {CH_NUM{RST_WIDTH}};
         pulse_gap   <= RST_GAP;
         ch_en       <= {CH_NUM{1'b1}};
         trig        <= 1'b0;
         ack_data    <= '0;
         ack_flag    <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         ack_flag    <= 1'b0;
         frame_err   <= 1'b0;
         r_trig_pend <= 1'b0;
         // Key and frame requests landing together collapse into one strobe.
         trig        <= r_trig_pend | key_trig;
         case (r_state)
            S_IDLE: begin
               if (pi_flag && (pi_data == HEADER)) begin
                  r_cnt  <= CW'(1);
                  r_sum  <= HEADER;
                  r_idle <= '0;
               end
            end
            S_RECV: begin
               if (pi_flag) begin
                  r_idle <= '0;
                  r_cnt  <= r_cnt + CW'(1);
                  if (r_cnt == CW'(1)) r_mask <= pi_data[CH_NUM-1:0];
                  for (int k = 0; k < int'(CH_NUM); k++) begin
                     if (r_cnt == CW'(2 + 2 * k)) r_width[k][15:8] <= pi_data;
                     if (r_cnt == CW'(3 + 2 * k)) r_width[k][7:0]  <= pi_data;
                  end
                  if (r_cnt == CW'(2 * CH_NUM + 2)) r_gap[15:8] <= pi_data;
                  if (r_cnt == CW'(2 * CH_NUM + 3)) r_gap[7:0]  <= pi_data;
                  // The checksum byte itself is held apart, not summed.
                  if (r_cnt == CW'(FRAME_LEN - 1)) r_csum <= pi_data;
                  else                             r_sum  <= r_sum + pi_data;
               end else if (w_timeout) begin
                  frame_err <= 1'b1;
                  r_cnt     <= '0;
                  r_sum     <= '0;
                  r_idle    <= '0;
               end else begin
                  r_idle <= r_idle + 26'd1;
               end
            end
            S_CHECK: begin
               ack_flag <= 1'b1;
               r_cnt    <= '0;
               if (w_match) begin
                  ack_data    <= ACK_OK;
                  r_trig_pend <= 1'b1;
                  pulse_gap   <= r_gap;
                  ch_en       <= r_mask;
                  for (int k = 0; k < int'(CH_NUM); k++) pulse_width[16*k +: 16] <= r_width[k];
               end else begin
                  ack_data  <= ACK_BAD;
                  frame_err <= 1'b1;
               end
            end
            default: r_cnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_pulse_cmd_parser.sv
// Bench for uart_pulse_cmd_parser: frame-level reference model checked every cycle, directed
// scenarios with literal expectations, then randomized frames, garbage, timeouts and key triggers.
module tb_uart_pulse_cmd_parser;

   localparam int CH = 2;
   localparam int L  = 2 * CH + 5;
   localparam int TO = 1000;

   typedef logic [7:0] byte_q_t [$];

   logic              clk;
   logic              rst_n;
   logic [7:0]        pi_data;
   logic              pi_flag;
   logic              key_trig;
   logic [CH*16-1:0]  pulse_width;
   logic [15:0]       pulse_gap;
   logic [CH-1:0]     ch_en;
   logic              trig;
   logic [7:0]        ack_data;
   logic              ack_flag;
   logic              frame_err;
   logic [1:0]        dbg_state;

   logic [7:0]        pi_data4;
   logic              pi_flag4;
   logic [63:0]       pulse_width4;
   logic [15:0]       pulse_gap4;
   logic [3:0]        ch_en4;
   logic              trig4;
   logic [7:0]        ack_data4;
   logic              ack_flag4;
   logic              frame_err4;
   logic [1:0]        dbg_state4;

   int n_assert = 0;
   int n_fail   = 0;
   int trig_cnt = 0;
   int ack_cnt  = 0;
   int err_cnt  = 0;
   logic key_rand;

   // Reference model state
   logic [15:0] m_w [CH];
   logic [15:0] m_gap;
   logic [CH-1:0] m_en;
   logic        m_trig, m_ack_flag, m_err;
   logic [7:0]  m_ack_data;
   logic        m_in_frame, m_chk_pend, m_trig_pend, m_fire, m_busy;
   int          m_idle;
   byte_q_t     m_fq;
   logic [7:0]  m_sum;

   uart_pulse_cmd_parser #(.CH_NUM(CH), .TIMEOUT_CYC(26'd1000)) u_dut (
      .sys_clk(clk), .sys_rst_n(rst_n), .pi_data(pi_data), .pi_flag(pi_flag),
      .key_trig(key_trig), .pulse_width(pulse_width), .pulse_gap(pulse_gap),
      .ch_en(ch_en), .trig(trig), .ack_data(ack_data), .ack_flag(ack_flag),
      .frame_err(frame_err), .dbg_state(dbg_state)
   );

   uart_pulse_cmd_parser #(.CH_NUM(4), .TIMEOUT_CYC(26'd1000)) u_dut4 (
      .sys_clk(clk), .sys_rst_n(rst_n), .pi_data(pi_data4), .pi_flag(pi_flag4),
      .key_trig(1'b0), .pulse_width(pulse_width4), .pulse_gap(pulse_gap4),
      .ch_en(ch_en4), .trig(trig4), .ack_data(ack_data4), .ack_flag(ack_flag4),
      .frame_err(frame_err4), .dbg_state(dbg_state4)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         for (int k = 0; k < CH; k++) m_w[k] = 16'd5;
         m_gap = 16'd5; m_en = '1;
         m_trig = 0; m_ack_flag = 0; m_err = 0; m_ack_data = 8'h00;
         m_in_frame = 0; m_chk_pend = 0; m_trig_pend = 0; m_idle = 0;
         m_fq.delete();
      end else begin
         m_busy = 0;
         m_fire = m_trig_pend;
         m_trig_pend = 0;
         m_ack_flag = 0;
         m_err = 0;
         if (m_chk_pend) begin
            m_chk_pend = 0;
            m_busy = 1;
            m_sum = 8'h00;
            for (int i = 0; i < L - 1; i++) m_sum = m_sum + m_fq[i];
            m_ack_flag = 1;
            if (m_sum == m_fq[L-1]) begin
               for (int k = 0; k < CH; k++) m_w[k] = {m_fq[2+2*k], m_fq[3+2*k]};
               m_gap = {m_fq[2*CH+2], m_fq[2*CH+3]};
               m_en = m_fq[1][CH-1:0];
               m_ack_data = 8'hA5;
               m_trig_pend = 1;
            end else begin
               m_ack_data = 8'h5A;
               m_err = 1;
            end
         end
         m_trig = m_fire | key_trig;
         if (m_busy) begin
            m_idle = 0;
         end else if (!m_in_frame) begin
            if (pi_flag && pi_data == 8'h07) begin
               m_in_frame = 1;
               m_fq.delete();
               m_fq.push_back(pi_data);
               m_idle = 0;
            end
         end else if (pi_flag) begin
            m_fq.push_back(pi_data);
            m_idle = 0;
            if (m_fq.size() == L) begin
               m_in_frame = 0;
               m_chk_pend = 1;
            end
         end else begin
            m_idle++;
            if (m_idle == TO) begin
               m_in_frame = 0;
               m_err = 1;
            end
         end
      end
   end

   // ---------------- scoreboard compare ----------------
   initial forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < CH; k++)
         chk($sformatf("width%0d", k), 64'(pulse_width[16*k +: 16]), 64'(m_w[k]));
      chk("gap", 64'(pulse_gap), 64'(m_gap));
      chk("ch_en", 64'(ch_en), 64'(m_en));
      chk("trig", 64'(trig), 64'(m_trig));
      chk("ack_flag", 64'(ack_flag), 64'(m_ack_flag));
      chk("ack_data", 64'(ack_data), 64'(m_ack_data));
      chk("frame_err", 64'(frame_err), 64'(m_err));
      if (trig === 1'b1)      trig_cnt++;
      if (ack_flag === 1'b1)  ack_cnt++;
      if (frame_err === 1'b1) err_cnt++;
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input logic f, input logic [7:0] d, input logic k);
      pi_flag  = f;
      pi_data  = d;
      key_trig = k | (key_rand && ($urandom_range(0, 15) == 0));
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'($urandom_range(0, 255)), 1'b0);
   endtask

   task automatic send_bytes(input byte_q_t q, input int max_gap);
      for (int i = 0; i < q.size(); i++) begin
         cyc(1'b1, q[i], 1'b0);
         if (max_gap > 0 && i < q.size() - 1) idle($urandom_range(0, max_gap));
      end
   endtask

   function automatic byte_q_t make_frame(input logic [7:0] mask, input logic [15:0] w0,
                                          input logic [15:0] w1, input logic [15:0] g,
                                          input logic corrupt);
      byte_q_t q;
      logic [7:0] s;
      q = {8'h07, mask, w0[15:8], w0[7:0], w1[15:8], w1[7:0], g[15:8], g[7:0]};
      s = 8'h00;
      foreach (q[i]) s = s + q[i];
      q.push_back(corrupt ? s + 8'd1 : s);
      return q;
   endfunction

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      n_fail++;
      $display("FAIL watchdog: stimulus still running at %0t, required to finish earlier", $time);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      byte_q_t q;
      byte_q_t q4;
      int t0, a0, e0, n_to, r, nb;
      rst_n = 1'b0;
      pi_flag = 1'b0; pi_data = 8'h00; key_trig = 1'b0; key_rand = 1'b0;
      pi_flag4 = 1'b0; pi_data4 = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_width", 64'(pulse_width), 64'h0005_0005);
      chk("rst_gap", 64'(pulse_gap), 64'd5);
      chk("rst_ch_en", 64'(ch_en), 64'b11);
      chk("rst_trig", 64'(trig), 64'd0);
      chk("rst_ack", 64'({ack_flag, ack_data}), 64'd0);
      chk("rst_err", 64'(frame_err), 64'd0);
      chk("rst_state", 64'(dbg_state), 64'd0);
      chk("rst_width4", pulse_width4, 64'h0005_0005_0005_0005);
      chk("rst_ch_en4", 64'(ch_en4), 64'hF);
      rst_n = 1'b1;
      idle(3);

      // Bad checksum: outputs keep reset values
      t0 = trig_cnt; a0 = ack_cnt; e0 = err_cnt;
      send_bytes(make_frame(8'h03, 16'd10, 16'd20, 16'd5, 1'b1), 0);
      idle(6);
      chk("bad_err_cnt", 64'(err_cnt - e0), 64'd1);
      chk("bad_ack_cnt", 64'(ack_cnt - a0), 64'd1);
      chk("bad_trig_cnt", 64'(trig_cnt - t0), 64'd0);
      chk("bad_ack_data", 64'(ack_data), 64'h5A);
      chk("bad_width", 64'(pulse_width), 64'h0005_0005);
      chk("bad_gap_en", 64'({pulse_gap, ch_en}), 64'({16'd5, 2'b11}));

      // Good frame with exact latency
      t0 = trig_cnt; a0 = ack_cnt; e0 = err_cnt;
      q = make_frame(8'h03, 16'd10, 16'd20, 16'd5, 1'b0);
      chk("good_cksum", 64'(q[8]), 64'h2D);
      for (int i = 0; i < 8; i++) cyc(1'b1, q[i], 1'b0);
      cyc(1'b1, q[8], 1'b0);
      chk("lat_state_check", 64'(dbg_state), 64'd2);
      chk("lat_ack_early", 64'(ack_flag), 64'd0);
      chk("lat_width_early", 64'(pulse_width), 64'h0005_0005);
      idle(1);
      chk("lat_ack", 64'({ack_flag, ack_data}), 64'h1A5);
      chk("lat_width", 64'(pulse_width), 64'h0014_000A);
      chk("lat_trig_early", 64'(trig), 64'd0);
      idle(1);
      chk("lat_trig", 64'(trig), 64'd1);
      chk("lat_ack_drop", 64'(ack_flag), 64'd0);
      idle(1);
      chk("lat_trig_drop", 64'(trig), 64'd0);
      idle(3);
      chk("good_model_width", 64'({m_w[1], m_w[0]}), 64'h0014_000A);
      chk("good_gap_en", 64'({pulse_gap, ch_en}), 64'({16'd5, 2'b11}));
      chk("good_counts", 64'({trig_cnt - t0, ack_cnt - a0, err_cnt - e0}), {32'd1, 32'd1, 32'd0});

      // Garbage then mask 01
      send_bytes('{8'h55, 8'hAA}, 0);
      send_bytes(make_frame(8'h01, 16'd10, 16'd20, 16'd5, 1'b0), 1);
      idle(6);
      chk("mask_ch_en", 64'(ch_en), 64'b01);
      chk("mask_ack", 64'(ack_data), 64'hA5);

      // Timeout abort then zero-valued frame
      a0 = ack_cnt; e0 = err_cnt;
      send_bytes('{8'h07, 8'h03, 8'h00}, 0);
      idle(1005);
      chk("to_err_cnt", 64'(err_cnt - e0), 64'd1);
      chk("to_ack_cnt", 64'(ack_cnt - a0), 64'd0);
      chk("to_state", 64'(dbg_state), 64'd0);
      send_bytes(make_frame(8'h03, 16'h1234, 16'h0000, 16'h0000, 1'b0), 0);
      idle(6);
      chk("to_after_width", 64'(pulse_width), 64'h0000_1234);
      chk("to_after_gap", 64'(pulse_gap), 64'd0);

      // Byte landing in the timeout cycle keeps the frame alive
      a0 = ack_cnt; e0 = err_cnt;
      q = make_frame(8'h03, 16'd7, 16'd8, 16'd9, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, q[i], 1'b0);
      idle(TO - 1);
      for (int i = 3; i < L; i++) cyc(1'b1, q[i], 1'b0);
      idle(6);
      chk("edge_err_cnt", 64'(err_cnt - e0), 64'd0);
      chk("edge_ack_cnt", 64'(ack_cnt - a0), 64'd1);
      chk("edge_width", 64'(pulse_width), 64'h0008_0007);
      chk("edge_gap", 64'(pulse_gap), 64'd9);

      // Key trigger alone
      t0 = trig_cnt;
      cyc(1'b0, 8'h00, 1'b1);
      chk("key_next_cycle", 64'(trig), 64'd1);
      idle(3);
      chk("key_trig_cnt", 64'(trig_cnt - t0), 64'd1);
      chk("key_width_kept", 64'(pulse_width), 64'h0008_0007);

      // Key coincident with frame trigger
      t0 = trig_cnt;
      send_bytes(make_frame(8'h02, 16'd1, 16'd2, 16'd3, 1'b0), 0);
      idle(1);
      cyc(1'b0, 8'h00, 1'b1);
      idle(4);
      chk("merge_trig_cnt", 64'(trig_cnt - t0), 64'd1);
      chk("merge_ch_en", 64'(ch_en), 64'b10);

      // Reset mid-frame
      q = make_frame(8'h03, 16'd100, 16'd200, 16'd300, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b1, q[i], 1'b0);
      pi_flag = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      chk("mrst_width", 64'(pulse_width), 64'h0005_0005);
      chk("mrst_gap_en", 64'({pulse_gap, ch_en}), 64'({16'd5, 2'b11}));
      chk("mrst_ack_state", 64'({ack_data, dbg_state}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      send_bytes(q, 0);
      idle(6);
      chk("mrst_after_width", 64'(pulse_width), 64'h00C8_0064);
      chk("mrst_after_gap", 64'(pulse_gap), 64'h012C);

      // Four-channel instance: lane ordering
      q4 = {8'h07, 8'h0F, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04,
            8'h00, 8'h06, 8'h26};
      foreach (q4[i]) begin
         pi_flag4 = 1'b1; pi_data4 = q4[i];
         @(negedge clk);
      end
      pi_flag4 = 1'b0;
      repeat (6) @(negedge clk);
      chk("ch4_width", pulse_width4, 64'h0004_0003_0002_0001);
      chk("ch4_gap_en", 64'({pulse_gap4, ch_en4}), 64'({16'd6, 4'hF}));
      chk("ch4_ack", 64'(ack_data4), 64'hA5);
      chk("ch4_idle_out", 64'({trig4, ack_flag4, frame_err4, dbg_state4}), 64'd0);

      // Randomized traffic
      key_rand = 1'b1;
      n_to = 0;
      for (int it = 0; it < 150; it++) begin
         r = $urandom_range(0, 19);
         q = make_frame(8'($urandom_range(0, 255)),
                        ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 65535)),
                        16'($urandom_range(0, 65535)),
                        ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 65535)),
                        ($urandom_range(0, 3) == 0));
         if (r == 0) begin
            repeat ($urandom_range(1, 3)) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0);
            idle($urandom_range(0, 2));
         end else if (r == 1 && n_to < 3) begin
            nb = $urandom_range(1, L - 2);
            for (int i = 0; i < nb; i++) cyc(1'b1, q[i], 1'b0);
            idle($urandom_range(TO - 1, TO + 3));
            n_to++;
         end else begin
            send_bytes(q, 2);
            idle($urandom_range(0, 4));
         end
      end
      key_rand = 1'b0;
      idle(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
